regfile_dump_streamer: RTL and testbench
========================================

Name: regfile_dump_streamer

Overview:
- Debug stage directly downstream of the register file's debug read port.
- On a start pulse it walks the debug select across registers x0..x(NUM_REGS-1) and captures each debug read value.
- It serialises the captured values as a byte stream to the UART transmitter over a valid/ready handshake.
- It asserts a halt request while dumping, so the core top can freeze the register file and the dump stays coherent.

Parameters:
- WIDTH, 32, register width in bits; must be a multiple of 8.
- NUM_REGS, 32, number of registers dumped, starting at x0; range 1..32.
- SYNC_BYTE, 8'hA5, frame header byte sent once before the first register.
- SEND_INDEX, 1, 1 = each register is preceded by its index byte {3'b000, idx}; 0 = data bytes only.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  dump request; sampled only in IDLE.
- dbg_sel  out  5  register index driven to the register file's debug select.
- dbg_data  in  WIDTH  register file debug read value; combinational from dbg_sel.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts the byte this cycle.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- halt_req  out  1  equals busy; the core must stall while it is high.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE; dbg_sel = 0; tx_data = 0; tx_valid = 0; busy = halt_req = done = 0.
  - Register index and byte counters clear to 0. The shift register clears to 0.
  - Reset mid-dump aborts immediately. No partial-frame recovery; the host resyncs on SYNC_BYTE.
- Byte transfer: occurs on a rising edge with tx_valid=1 and tx_ready=1.
  - tx_data and tx_valid stay stable until the transfer.
  - tx_valid never drops without a transfer.
  - tx_ready may be high before tx_valid.
- Register outputs: all outputs are registered. There is no combinational path from tx_ready to tx_valid.
- States:
  - IDLE: if start=1, load tx_data = SYNC_BYTE, set tx_valid=1 and busy=1, clear idx, and go to SEND_SYNC.
  - SEND_SYNC: on transfer, drive dbg_sel = idx, drop tx_valid, and go to SETTLE.
  - SETTLE: one cycle for the combinational read to settle. Then go to CAPTURE.
  - CAPTURE: latch dbg_data into the shift register and reset the byte counter.
    - If SEND_INDEX=1, present {3'b000, idx} and go to SEND_IDX.
    - Otherwise present the data MSB byte and go to SEND_DATA.
    - tx_valid rises at the CAPTURE edge.
  - SEND_IDX: on transfer, present the shift register MSB byte and go to SEND_DATA.
  - SEND_DATA: bytes go out MSB first (big-endian), WIDTH/8 bytes per register.
    - On each transfer, shift left 8 and increment the byte counter.
    - After the last byte transfer:
      - If idx == NUM_REGS-1, go to FINISH.
      - Otherwise increment idx, update dbg_sel, clear tx_valid, and go to SETTLE.
  - FINISH: tx_valid=0, busy=0, done=1 for exactly one cycle, then IDLE. dbg_sel returns to 0.
- start handling:
  - start while busy is ignored; it is not queued.
  - start held high continuously retriggers a new dump in the cycle after FINISH returns to IDLE.
- Frame length: 1 + NUM_REGS*(SEND_INDEX + WIDTH/8) bytes; 161 for the defaults.
- Minimum per-register overhead: 2 cycles (SETTLE, CAPTURE) in addition to the handshake cycles.
- Counter widths:
  - idx is 5 bits.
  - The byte counter is clog2(WIDTH/8) bits, minimum 1.
  - No wrap past NUM_REGS-1.
- x0 is dumped like any other register; the expected value is 0.
- dbg_data is captured only in CAPTURE. Changes to dbg_data during SEND_* do not affect the bytes sent.

Test Plan:
1. Reset values: hold reset=0 for 3 cycles with start=1 -> all outputs 0, no tx_valid. Release reset -> sync starts only at the first sampled edge.
2. Full dump with tx_ready=1 always:
   - Register model sets x1=32'h12345678 and x31=32'hDEADBEEF; all others equal index*0x01010101.
   - Expected: 161 bytes. Byte 0 = A5.
   - Bytes for x1: 01 12 34 56 78. Last five bytes: 1F DE AD BE EF.
   - done pulses once; busy falls in the same cycle done rises.
3. Backpressure: random tx_ready with ~30% duty -> identical 161-byte stream. tx_data is stable while tx_valid=1 and tx_ready=0, with no dropped or duplicated byte.
4. Ignored start: pulse start at byte 40 of a dump -> single frame only; busy stays high continuously.
5. Reset mid-dump: assert reset while in SEND_DATA for x7 -> tx_valid and busy drop asynchronously. A new start yields a fresh frame beginning with A5.
6. Parameter variant SEND_INDEX=0, NUM_REGS=4, WIDTH=32 -> 17 bytes: A5, then x0..x3 big-endian. dbg_sel sequence is 0,1,2,3, then back to 0.

Source files
------------

// File: rtl/regfile_dump_streamer.sv
// Walks the register file debug port across x0..x(NUM_REGS-1) and streams a framed big-endian byte dump
// to a UART transmitter over valid/ready, holding the core in halt while the frame is in flight.
module regfile_dump_streamer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter bit          SEND_INDEX = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [4:0]       dbg_sel,
  input  logic [WIDTH-1:0] dbg_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             halt_req,
  output logic             done
);

  localparam int unsigned NUM_BYTES = WIDTH / 8;
  localparam int unsigned BCW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [4:0]     LAST_IDX  = 5'(NUM_REGS - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NUM_BYTES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND_SYNC = 3'd1;
  localparam logic [2:0] S_SETTLE    = 3'd2;
  localparam logic [2:0] S_CAPTURE   = 3'd3;
  localparam logic [2:0] S_SEND_IDX  = 3'd4;
  localparam logic [2:0] S_SEND_DATA = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;

  logic [2:0]       state,    state_nxt;
  logic [4:0]       idx,      idx_nxt;
  logic [BCW-1:0]   byte_cnt, byte_cnt_nxt;
  logic [WIDTH-1:0] shift,    shift_nxt;
  logic [WIDTH-1:0] shift_sh;
  logic [4:0]       sel_nxt;
  logic [7:0]       tx_data_nxt;
  logic             tx_valid_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             xfer;

  assign xfer     = tx_valid && tx_ready;
  assign shift_sh = shift << 8;

  // State and all outputs are registered together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      byte_cnt <= '0;
      shift    <= '0;
      dbg_sel  <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      halt_req <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      byte_cnt <= byte_cnt_nxt;
      shift    <= shift_nxt;
      dbg_sel  <= sel_nxt;
      tx_data  <= tx_data_nxt;
      tx_valid <= tx_valid_nxt;
      busy     <= busy_nxt;
      halt_req <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    byte_cnt_nxt = byte_cnt;
    shift_nxt    = shift;
    sel_nxt      = dbg_sel;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    busy_nxt     = busy;
    done_nxt     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          tx_data_nxt  = SYNC_BYTE;
          tx_valid_nxt = 1'b1;
          busy_nxt     = 1'b1;
          idx_nxt      = '0;
          sel_nxt      = '0;
          state_nxt    = S_SEND_SYNC;
        end
      end
      S_SEND_SYNC: begin
        if (xfer) begin
          sel_nxt      = idx;
          tx_valid_nxt = 1'b0;
          state_nxt    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        // dbg_sel has been stable for two cycles here; this is the only sample point
        shift_nxt    = dbg_data;
        byte_cnt_nxt = '0;
        tx_valid_nxt = 1'b1;
        if (SEND_INDEX) begin
          tx_data_nxt = {3'b000, idx};
          state_nxt   = S_SEND_IDX;
        end else begin
          tx_data_nxt = dbg_data[WIDTH-1 -: 8];
          state_nxt   = S_SEND_DATA;
        end
      end
      S_SEND_IDX: begin
        if (xfer) begin
          tx_data_nxt = shift[WIDTH-1 -: 8];
          state_nxt   = S_SEND_DATA;
        end
      end
      S_SEND_DATA: begin
        if (xfer) begin
          shift_nxt    = shift_sh;
          byte_cnt_nxt = BCW'(byte_cnt + 1'b1);
          if (byte_cnt == LAST_BYTE) begin
            tx_valid_nxt = 1'b0;
            if (idx == LAST_IDX) begin
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
              sel_nxt   = '0;
              state_nxt = S_FINISH;
            end else begin
              idx_nxt   = 5'(idx + 5'd1);
              sel_nxt   = 5'(idx + 5'd1);
              state_nxt = S_SETTLE;
            end
          end else begin
            tx_data_nxt = shift_sh[WIDTH-1 -: 8];
          end
        end
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        tx_valid_nxt = 1'b0;
        busy_nxt     = 1'b0;
        sel_nxt      = '0;
        state_nxt    = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// Directed bench for regfile_dump_streamer: default 161-byte frame plus a 4-register, no-index variant.
module tb_regfile_dump_streamer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        halt_req;
  logic        done;
  bit          scramble;

  logic        b_start;
  logic [4:0]  b_sel;
  logic [31:0] b_data;
  logic [7:0]  b_txd;
  logic        b_valid;
  logic        b_ready;
  logic        b_busy;
  logic        b_halt;
  logic        b_done;

  int total;
  int bad;

  logic [7:0] byte_q[$];
  logic [7:0] exp_q[$];
  int         done_cnt;
  int         busy_gap;
  int         stab_err;
  int         done_busy_err;
  bit         timeout;

  regfile_dump_streamer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .halt_req (halt_req),
    .done     (done)
  );

  regfile_dump_streamer #(
    .WIDTH      (32),
    .NUM_REGS   (4),
    .SYNC_BYTE  (8'hA5),
    .SEND_INDEX (1'b0)
  ) dut_b (
    .clk      (clk),
    .reset    (reset),
    .start    (b_start),
    .dbg_sel  (b_sel),
    .dbg_data (b_data),
    .tx_data  (b_txd),
    .tx_valid (b_valid),
    .tx_ready (b_ready),
    .busy     (b_busy),
    .halt_req (b_halt),
    .done     (b_done)
  );

  function automatic logic [31:0] reg_val(input logic [4:0] r);
    if (r == 5'd1)  return 32'h12345678;
    if (r == 5'd31) return 32'hDEADBEEF;
    return {3'b000, r, 3'b000, r, 3'b000, r, 3'b000, r};
  endfunction

  // Scramble corrupts the read value whenever a byte is on the wire; capture must not see it
  assign dbg_data = (scramble && tx_valid) ? ~reg_val(dbg_sel) : reg_val(dbg_sel);
  assign b_data   = reg_val(b_sel);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic build_expected(input int nregs, input bit with_idx);
    logic [31:0] v;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int r = 0; r < nregs; r++) begin
      if (with_idx) exp_q.push_back({3'b000, 5'(r)});
      v = reg_val(5'(r));
      for (int b = 3; b >= 0; b--) exp_q.push_back(v[b*8 +: 8]);
    end
  endtask

  // Starts a frame on DUT A and collects transferred bytes until done
  task automatic run_frame(input int ready_pct, input int pulse_at, input bit hold);
    bit         pend;
    bit         rdy;
    logic [7:0] pend_data;
    int         n;
    bit         got_done;
    byte_q.delete();
    done_cnt = 0; busy_gap = 0; stab_err = 0; done_busy_err = 0; timeout = 0;
    pend = 0; pend_data = 8'h00; n = 0; got_done = 0;
    @(negedge clk);
    start = 1'b1;
    tx_ready = 1'b0;
    while (!got_done && n < 5000) begin
      @(negedge clk);
      n++;
      if (done) begin
        got_done = 1;
        done_cnt++;
        if (busy) done_busy_err++;
        start = hold;
      end else begin
        if (!busy) busy_gap++;
        if (pend && (!tx_valid || tx_data !== pend_data)) stab_err++;
        rdy = ($urandom_range(99) < ready_pct);
        if (tx_valid && rdy) byte_q.push_back(tx_data);
        pend = tx_valid && !rdy;
        pend_data = tx_data;
        tx_ready = rdy;
        start = hold || (byte_q.size() == pulse_at);
      end
    end
    if (!got_done) timeout = 1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    total++; if (dbg_sel !== 5'd0) begin bad++; $display("FAIL reset_dbg_sel got=%0d want=0", dbg_sel); end
    total++; if ({busy, halt_req, done} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b want=000", {busy, halt_req, done}); end
    reset = 1'b1;
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL release_no_early_sync got=%b want=0", tx_valid); end
    @(negedge clk);
    total++; if ({tx_valid, tx_data} !== {1'b1, 8'hA5}) begin bad++; $display("FAIL first_edge_sync got=%b/%h want=1/a5", tx_valid, tx_data); end
    total++; if ({busy, halt_req} !== 2'b11) begin bad++; $display("FAIL first_edge_busy got=%b want=11", {busy, halt_req}); end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_stream(input string name);
    int mism;
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++)
      if (byte_q[i] !== exp_q[i]) mism++;
    total++;
    if (mism != 0 || byte_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s_stream got_len=%0d want_len=%0d wrong_bytes=%0d", name, byte_q.size(), exp_q.size(), mism);
    end
  endtask

  task automatic test_full_dump();
    build_expected(32, 1'b1);
    run_frame(100, -1, 1'b0);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL full_timeout got=%b want=0", timeout); end
    total++; if (byte_q.size() != 161) begin bad++; $display("FAIL full_len got=%0d want=161", byte_q.size()); end
    if (byte_q.size() == 161) begin
      total++; if (byte_q[0] !== 8'hA5) begin bad++; $display("FAIL full_sync got=%h want=a5", byte_q[0]); end
      total++; if ({byte_q[1], byte_q[2], byte_q[3], byte_q[4], byte_q[5]} !== 40'h00_00000000) begin
        bad++; $display("FAIL full_x0 got=%h want=0000000000", {byte_q[1], byte_q[2], byte_q[3], byte_q[4], byte_q[5]}); end
      total++; if ({byte_q[6], byte_q[7], byte_q[8], byte_q[9], byte_q[10]} !== 40'h01_12345678) begin
        bad++; $display("FAIL full_x1 got=%h want=0112345678", {byte_q[6], byte_q[7], byte_q[8], byte_q[9], byte_q[10]}); end
      total++; if ({byte_q[156], byte_q[157], byte_q[158], byte_q[159], byte_q[160]} !== 40'h1F_DEADBEEF) begin
        bad++; $display("FAIL full_x31 got=%h want=1fdeadbeef", {byte_q[156], byte_q[157], byte_q[158], byte_q[159], byte_q[160]}); end
    end
    check_stream("full");
    total++; if (done_busy_err != 0 || busy_gap != 0) begin bad++; $display("FAIL full_busy_done got=%0d/%0d want=0/0", done_busy_err, busy_gap); end
    @(negedge clk);
    total++; if ({done, busy, tx_valid} !== 3'b000) begin bad++; $display("FAIL full_after_done got=%b want=000", {done, busy, tx_valid}); end
  endtask

  task automatic test_backpressure();
    build_expected(32, 1'b1);
    scramble = 1'b1;
    run_frame(30, -1, 1'b0);
    scramble = 1'b0;
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL bp_timeout got=%b want=0", timeout); end
    check_stream("bp");
    total++; if (stab_err != 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", stab_err); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done got=%0d want=1", done_cnt); end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    build_expected(32, 1'b1);
    run_frame(100, 40, 1'b0);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL ign_timeout got=%b want=0", timeout); end
    check_stream("ign");
    total++; if (busy_gap != 0) begin bad++; $display("FAIL ign_busy_gap got=%0d want=0", busy_gap); end
    repeat (2) @(negedge clk);
    total++; if ({busy, tx_valid} !== 2'b00) begin bad++; $display("FAIL ign_no_requeue got=%b want=00", {busy, tx_valid}); end
  endtask

  task automatic test_back_to_back();
    build_expected(32, 1'b1);
    run_frame(100, -1, 1'b1);
    check_stream("b2b");
    @(negedge clk);
    total++; if ({busy, tx_valid, done} !== 3'b000) begin bad++; $display("FAIL b2b_idle got=%b want=000", {busy, tx_valid, done}); end
    @(negedge clk);
    total++; if ({busy, tx_valid, tx_data} !== {2'b11, 8'hA5}) begin bad++; $display("FAIL b2b_retrigger got=%b/%b/%h want=1/1/a5", busy, tx_valid, tx_data); end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_dump();
    int cnt;
    int n;
    cnt = 0; n = 0;
    @(negedge clk);
    start = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cnt < 38 && n < 1000) begin
      if (tx_valid) cnt++;
      if (cnt < 38) begin @(negedge clk); n++; end
    end
    total++; if (cnt != 38) begin bad++; $display("FAIL mid_reach got=%0d want=38", cnt); end
    total++; if ({dbg_sel, tx_data} !== {5'd7, 8'h07}) begin bad++; $display("FAIL mid_x7_data got=%0d/%h want=7/07", dbg_sel, tx_data); end
    #2 reset = 1'b0;
    #1;
    total++; if ({tx_valid, busy, halt_req} !== 3'b000) begin bad++; $display("FAIL mid_async_drop got=%b want=000", {tx_valid, busy, halt_req}); end
    @(negedge clk);
    reset = 1'b1;
    build_expected(32, 1'b1);
    run_frame(100, -1, 1'b0);
    total++; if (byte_q.size() == 0 || byte_q[0] !== 8'hA5) begin bad++; $display("FAIL mid_resync got_len=%0d want first=a5", byte_q.size()); end
    check_stream("mid");
    @(negedge clk);
  endtask

  task automatic test_variant();
    logic [7:0] q[$];
    logic [4:0] sel_q[$];
    logic [4:0] want_sel[5];
    int         n;
    bit         got;
    want_sel = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0};
    n = 0; got = 0;
    build_expected(4, 1'b0);
    b_ready = 1'b1;
    sel_q.push_back(b_sel);
    @(negedge clk);
    b_start = 1'b1;
    while (!got && n < 500) begin
      @(negedge clk);
      n++;
      b_start = 1'b0;
      if (b_sel != sel_q[sel_q.size()-1]) sel_q.push_back(b_sel);
      if (b_done) got = 1;
      else if (b_valid) q.push_back(b_txd);
    end
    total++; if (got !== 1'b1) begin bad++; $display("FAIL var_timeout got=%b want=1", got); end
    total++; if (q.size() != 17) begin bad++; $display("FAIL var_len got=%0d want=17", q.size()); end
    if (q.size() == 17) begin
      total++; if ({q[0], q[5], q[6], q[7], q[8]} !== 40'hA5_12345678) begin
        bad++; $display("FAIL var_sync_x1 got=%h want=a512345678", {q[0], q[5], q[6], q[7], q[8]}); end
      total++; if ({q[13], q[14], q[15], q[16]} !== 32'h03030303) begin
        bad++; $display("FAIL var_x3 got=%h want=03030303", {q[13], q[14], q[15], q[16]}); end
      for (int i = 0; i < 17; i++) begin
        total++;
        if (q[i] !== exp_q[i]) begin bad++; $display("FAIL var_byte%0d got=%h want=%h", i, q[i], exp_q[i]); end
      end
    end
    total++; if (sel_q.size() != 5) begin bad++; $display("FAIL var_sel_len got=%0d want=5", sel_q.size()); end
    if (sel_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (sel_q[i] !== want_sel[i]) begin bad++; $display("FAIL var_sel%0d got=%0d want=%0d", i, sel_q[i], want_sel[i]); end
      end
    end
    total++; if ({b_busy, b_halt} !== 2'b00) begin bad++; $display("FAIL var_done_busy got=%b want=00", {b_busy, b_halt}); end
  endtask

  initial begin
    total = 0; bad = 0; scramble = 1'b0;
    reset = 1'b0; start = 1'b0; tx_ready = 1'b0;
    b_start = 1'b0; b_ready = 1'b0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_dump();
    test_variant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
